// File: rtl/periph_bus_pkg.sv
// periph_bus_pkg: shared types and constants for the peripheral bus controller
package periph_bus_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  localparam int NUM_SLV = 8;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 12;
endpackage

// File: rtl/onehot8_enc.sv
// onehot8_enc: one-hot select to slave index, valid only when exactly one bit is set
module onehot8_enc
  import periph_bus_pkg::*;
(
  input  logic [NUM_SLV-1:0] sel,
  output logic [2:0]         idx,
  output logic               valid
);
  assign idx = {|sel[7:4], |{sel[7:6], sel[3:2]}, |{sel[7], sel[5], sel[3], sel[1]}};
  assign valid = |sel && ~|(sel & (sel - 8'd1));
endmodule

// File: rtl/periph_bus_ctrl.sv
// periph_bus_ctrl: converts one core load/store into an APB-style SETUP/ACCESS transfer with timeout
module periph_bus_ctrl
  import periph_bus_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int TIMEOUT = 15
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      req_i,
  input  logic                      we_i,
  input  logic [NUM_SLV-1:0]        sel_i,
  input  logic [ADDR_W-1:0]         addr_i,
  input  logic [DATA_W-1:0]         wdata_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o,
  output logic [DATA_W-1:0]         rdata_o,
  output logic [NUM_SLV-1:0]        psel_o,
  output logic                      penable_o,
  output logic                      pwrite_o,
  output logic [ADDR_W-1:0]         paddr_o,
  output logic [DATA_W-1:0]         pwdata_o,
  input  logic [NUM_SLV*DATA_W-1:0] prdata_i,
  input  logic [NUM_SLV-1:0]        pready_i,
  input  logic [NUM_SLV-1:0]        pslverr_i
);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [NUM_SLV-1:0] enc_sel;
  logic [2:0] idx;
  logic vld, rdy, slverr, timeout;
  logic [DATA_W-1:0] rd;
  // In IDLE the encoder validates the incoming select; afterwards it indexes the captured one
  assign enc_sel = state == IDLE ? sel_i : psel_o;
  onehot8_enc u_enc (.sel(enc_sel), .idx(idx), .valid(vld));
  assign rdy = pready_i[idx];
  assign slverr = pslverr_i[idx];
  assign rd = prdata_i[idx*DATA_W +: DATA_W];
  assign timeout = cnt == CW'(TIMEOUT);
  // Next-state: invalid selects skip the bus and report straight from RESP
  always_comb begin
    state_n = IDLE;
    state_n = state == IDLE   ? (req_i ? (vld ? SETUP : RESP) : IDLE) :
              state == SETUP  ? ACCESS :
              state == ACCESS ? ((rdy || timeout) ? RESP : ACCESS) : IDLE;
  end
  // State, counter and all outputs are registered from the next state
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state     <= IDLE;
      cnt       <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      err_o     <= 1'b0;
      rdata_o   <= '0;
      psel_o    <= '0;
      penable_o <= 1'b0;
      pwrite_o  <= 1'b0;
      paddr_o   <= '0;
      pwdata_o  <= '0;
    end else begin
      state     <= state_n;
      cnt       <= state == SETUP ? '0 : (state == ACCESS && !timeout) ? cnt + 1'b1 : cnt;
      busy_o    <= state_n != IDLE;
      done_o    <= state_n == RESP;
      err_o     <= state_n == RESP && (state == IDLE || !rdy || slverr);
      penable_o <= state_n == ACCESS;
      psel_o    <= state_n == SETUP ? sel_i : state_n == RESP ? '0 : psel_o;
      if (state_n == RESP) rdata_o <= (state == ACCESS && rdy && !pwrite_o) ? rd : '0;
      if (state_n == SETUP) begin
        pwrite_o <= we_i;
        paddr_o  <= addr_i;
        pwdata_o <= wdata_i;
      end
    end
  end
endmodule

// File: tb/tb_periph_bus_ctrl.sv
// tb_periph_bus_ctrl: table-driven checks of transfers, decode errors, timeout and reset
module tb_periph_bus_ctrl;
  logic clk_i = 0;
  logic rst_ni;
  logic req_i, we_i;
  logic [7:0] sel_i;
  logic [11:0] addr_i;
  logic [31:0] wdata_i;
  logic busy_o, done_o, err_o, penable_o, pwrite_o;
  logic [31:0] rdata_o, pwdata_o;
  logic [7:0] psel_o;
  logic [11:0] paddr_o;
  logic [255:0] prdata_i;
  logic [7:0] pready_i, pslverr_i;
  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] hold_rd = '0;

  typedef struct {
    logic        we;
    logic [7:0]  sel;
    logic [11:0] addr;
    logic [31:0] wdata;
    int          slv;
    logic [31:0] prdata;
    int          rdy_at;
    logic [7:0]  rdy;
    logic [7:0]  bg_rdy;
    logic [7:0]  slverr;
    logic        dec;
    int          exp_done;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;
  vec_t vecs[8];

  periph_bus_ctrl #(.DATA_W(32), .ADDR_W(12), .TIMEOUT(15)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i), .sel_i(sel_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .rdata_o(rdata_o), .psel_o(psel_o), .penable_o(penable_o),
    .pwrite_o(pwrite_o), .paddr_o(paddr_o), .pwdata_o(pwdata_o),
    .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run(input vec_t v);
    int done_cyc;
    logic [31:0] got_err, got_rd;
    done_cyc = -1;
    got_err = '0;
    got_rd = '0;
    @(negedge clk_i);
    chk("idle_before", {31'd0, busy_o}, 32'd0);
    req_i = 1; we_i = v.we; sel_i = v.sel; addr_i = v.addr; wdata_i = v.wdata;
    pready_i = v.bg_rdy; pslverr_i = v.slverr;
    for (int k = 0; k < 8; k++) prdata_i[k*32 +: 32] = (k == v.slv) ? v.prdata : (32'hA5A5_0000 | k);
    @(negedge clk_i);
    req_i = 0;
    for (int c = 1; c <= 40; c++) begin
      if (c > 1) @(negedge clk_i);
      pready_i = (c == v.rdy_at) ? (v.bg_rdy | v.rdy) : v.bg_rdy;
      if (c == 1) begin
        chk("c1_psel", {24'd0, psel_o}, v.dec ? 32'd0 : {24'd0, v.sel});
        chk("c1_busy", {31'd0, busy_o}, 32'd1);
        chk("c1_penable", {31'd0, penable_o}, 32'd0);
        chk("rdata_hold", rdata_o, hold_rd);
      end
      if (c == 2 && !v.dec) begin
        chk("c2_penable", {31'd0, penable_o}, 32'd1);
        chk("c2_psel", {24'd0, psel_o}, {24'd0, v.sel});
        chk("c2_paddr", {20'd0, paddr_o}, {20'd0, v.addr});
        chk("c2_pwrite", {31'd0, pwrite_o}, {31'd0, v.we});
        chk("c2_pwdata", pwdata_o, v.wdata);
      end
      if (done_o) begin
        done_cyc = c;
        got_err = {31'd0, err_o};
        got_rd = rdata_o;
        break;
      end
      chk("err_idle", {31'd0, err_o}, 32'd0);
    end
    chk("done_cycle", 32'(done_cyc), 32'(v.exp_done));
    chk("done_err", got_err, {31'd0, v.exp_err});
    chk("done_rdata", got_rd, v.exp_rd);
    chk("resp_psel", {24'd0, psel_o}, 32'd0);
    hold_rd = v.exp_rd;
  endtask

  initial begin
    //          we    sel    addr     wdata         slv prdata        rdy rdy    bg     slverr dec done err rdata
    vecs[0] = '{1'b0, 8'h08, 12'h010, 32'h0,        3, 32'hDEADBEEF, 2,  8'h08, 8'h00, 8'h00, 0, 3,  0, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 8'h01, 12'h024, 32'h12345678, 0, 32'h55555555, 6,  8'h01, 8'h00, 8'h00, 0, 7,  0, 32'h0};
    vecs[2] = '{1'b0, 8'h00, 12'h030, 32'h0,        0, 32'h11111111, 0,  8'h00, 8'hFF, 8'h00, 1, 1,  1, 32'h0};
    vecs[3] = '{1'b0, 8'h81, 12'h040, 32'h0,        0, 32'h22222222, 0,  8'h00, 8'hFF, 8'h00, 1, 1,  1, 32'h0};
    vecs[4] = '{1'b0, 8'h20, 12'h050, 32'h0,        5, 32'h33333333, 0,  8'h00, 8'hDF, 8'h00, 0, 18, 1, 32'h0};
    vecs[5] = '{1'b1, 8'h40, 12'h060, 32'hCAFEF00D, 6, 32'h44444444, 2,  8'h40, 8'h00, 8'h40, 0, 3,  1, 32'h0};
    vecs[6] = '{1'b0, 8'h80, 12'h070, 32'h0,        7, 32'h00007777, 3,  8'h80, 8'h00, 8'h7F, 0, 4,  0, 32'h00007777};
    vecs[7] = '{1'b0, 8'h02, 12'h080, 32'h0,        1, 32'h11112222, 17, 8'h02, 8'h00, 8'h00, 0, 18, 0, 32'h11112222};
    rst_ni = 0; req_i = 0; we_i = 0; sel_i = 0; addr_i = 0; wdata_i = 0;
    prdata_i = '0; pready_i = 0; pslverr_i = 0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_outs", {busy_o, done_o, err_o, penable_o, pwrite_o, 27'd0}, 32'd0);
    chk("rst_bus", {psel_o, paddr_o, 12'd0} | rdata_o | pwdata_o, 32'd0);
    rst_ni = 1;
    for (int i = 0; i < 8; i++) run(vecs[i]);
    @(negedge clk_i);
    req_i = 1; we_i = 1; sel_i = 8'h04; addr_i = 12'hABC; wdata_i = 32'h0F0F0F0F;
    pready_i = 0; pslverr_i = 0;
    @(negedge clk_i);
    req_i = 0;
    @(negedge clk_i);
    chk("pre_rst_penable", {31'd0, penable_o}, 32'd1);
    rst_ni = 0;
    @(negedge clk_i);
    rst_ni = 1;
    chk("mid_rst_outs", {busy_o, done_o, err_o, penable_o, pwrite_o, 27'd0}, 32'd0);
    chk("mid_rst_psel", {24'd0, psel_o}, 32'd0);
    chk("mid_rst_data", rdata_o | pwdata_o | {20'd0, paddr_o}, 32'd0);
    hold_rd = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      chk("post_rst_nodone", {30'd0, done_o, busy_o}, 32'd0);
    end
    run(vecs[0]);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/periph_bus_ctrl.md
# periph_bus_ctrl

Sequential peripheral-bus controller that consumes the 8-bit one-hot peripheral select produced by the core's 3-to-8 address decoder. It converts a single CPU load/store request into an APB-style two-phase transfer (SETUP, then ACCESS) on one of 8 slaves. It waits for the slave's ready with a bounded timeout and returns read data or an error to the core's stall/writeback logic.

## Interface
- DATA_W, 32, data bus width
- ADDR_W, 12, peripheral-local address width
- TIMEOUT, 15, maximum ACCESS cycles before abort (≥1)

- clk_i  in  1  single clock, rising edge
- rst_ni  in  1  reset, synchronous, active-low
- req_i  in  1  transfer request from core, sampled only in IDLE
- we_i  in  1  1 = write, 0 = read
- sel_i  in  8  one-hot peripheral select from the address decoder
- addr_i  in  ADDR_W  peripheral-local address
- wdata_i  in  DATA_W  write data
- busy_o  out  1  high whenever state ≠ IDLE (core stall)
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  error flag, valid with done_o
- rdata_o  out  DATA_W  read data, valid with done_o, held until next done_o
- psel_o  out  8  one-hot slave select
- penable_o  out  1  ACCESS-phase strobe
- pwrite_o  out  1  registered we_i
- paddr_o  out  ADDR_W  registered addr_i
- pwdata_o  out  DATA_W  registered wdata_i
- prdata_i  in  8*DATA_W  slave read data, slave k at bits [k*DATA_W +: DATA_W]
- pready_i  in  8  per-slave ready
- pslverr_i  in  8  per-slave error, meaningful only with ready

## Operation
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE: if req_i=1 and sel_i is exactly one-hot → register we/addr/wdata/sel, go to SETUP. If req_i=1 and sel_i is zero or multi-hot → decode error, go to RESP with err=1, rdata=0, no bus activity. req_i=0 → stay.
- SETUP: psel_o = captured sel, penable_o=0; unconditionally go to ACCESS, clear timeout counter.
- ACCESS: psel_o held, penable_o=1. Only the selected slave's pready/pslverr/prdata are observed; others are ignored.
  - selected pready=1 → capture rdata (read only; writes leave rdata_o at 0) and err=pslverr, then go to RESP.
  - otherwise increment counter; when counter reaches TIMEOUT with no ready → go to RESP with err=1, rdata=0.
- RESP: done_o=1 for exactly this cycle, psel_o=0, penable_o=0; go to IDLE. req_i is ignored here.
- err_o is meaningful only while done_o=1; it is driven 0 otherwise.
- Timeout counter width is $clog2(TIMEOUT+1) and saturates at TIMEOUT; it never wraps.

## Timing
- Reset (rst_ni=0 at an edge): state=IDLE. All outputs become 0 on that edge: busy, done, err, rdata, psel, penable, pwrite, paddr, pwdata.
- Reset mid-transfer: the transfer is abandoned, psel_o drops on the reset edge, and no done_o is issued.
- Normal transfer accepted at edge 0 (IDLE, req_i=1):
  - SETUP in cycle 1.
  - ACCESS from cycle 2.
  - If ready is sampled at edge n, RESP/done_o occurs in cycle n+1.
  - Minimum latency, with ready in the first ACCESS cycle: done_o in cycle 3.
- Decode error accepted at edge 0: done_o=1, err_o=1 in cycle 1.
- Timeout: done_o in cycle 3+TIMEOUT when ready never comes.
- Back-to-back: the next request is accepted earliest at the IDLE cycle after RESP.
- busy_o is high from cycle 1 through the RESP cycle inclusive.
- All outputs are registered; there is no combinational path from any input to any output.

## Structure
- Package periph_bus_pkg:
  - state enum {IDLE, SETUP, ACCESS, RESP}
  - localparam NUM_SLV=8
  - default DATA_W/ADDR_W constants
- Sub-module onehot8_enc: combinational. Takes 8-bit sel and outputs a 3-bit index plus a valid flag (exactly one bit set). The index selects the prdata/pready/pslverr slice.
- Remaining logic (FSM, timeout counter, capture registers) lives in periph_bus_ctrl; expected size ~150–250 lines.

## Test plan
- Read, slave 3 ready immediately: sel_i=8'h08, we_i=0, addr_i=12'h010, prdata slice 3=32'hDEADBEEF → psel_o=8'h08 in cycles 1–2, penable in cycle 2, done_o in cycle 3 with rdata_o=32'hDEADBEEF, err_o=0.
- Write, slave 0 with 4 wait cycles: sel_i=8'h01, we_i=1, wdata_i=32'h12345678 → pwdata_o/pwrite_o stable through ACCESS, done_o in cycle 7, err_o=0, rdata_o=0.
- Decode error: sel_i=8'h00 and, separately, sel_i=8'h81 → psel_o stays 0, done_o=1 and err_o=1 in cycle 1.
- Timeout, TIMEOUT=15, slave 5 never ready → done_o in cycle 18, err_o=1, rdata_o=0. Asserting pready of a non-selected slave must not end the transfer.
- Slave error: slave 6 returns pready=1, pslverr=1 → done_o with err_o=1.
- Reset in ACCESS: rst_ni=0 for one edge → all outputs 0 the following cycle, no done_o. A new request immediately afterward completes normally.
